beam_trigger_scaler: RTL and testbench

//  Per-beam trigger rate scaler in the ifclk domain, directly downstream of the

---
 rtl/beam_trigger_scaler_pkg.sv | 23 ++
 rtl/beam_trigger_scaler_if.sv | 17 +
 rtl/beam_trigger_scaler_holdoff_counter.sv | 55 +++++
 rtl/beam_trigger_scaler.sv | 106 ++++++++++
 tb/tb_beam_trigger_scaler.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/beam_trigger_scaler_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// beam_trigger_scaler_pkg : shared types and helpers for the beam scaler
// Revision: 1.0
// ------------------------------------------------------------------
package beam_trigger_scaler_pkg;

  localparam int SCAL_BITS_DEFAULT = 24;
  localparam int COUNT_FIELD_BITS  = 24;

  typedef struct packed {
    logic [7:0]  seq;
    logic [23:0] count;
  } scal_word_t;

  // Counts stick at the ceiling instead of wrapping back to zero.
  function automatic logic [23:0] sat_inc(input logic [23:0] value,
                                          input logic [23:0] max_value);
    return (value >= max_value) ? value : value + 24'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/beam_trigger_scaler_if.sv
`default_nettype none
// ------------------------------------------------------------------
// beam_trigger_scaler_if : readout bus between scaler and threshold loop
// Revision: 1.0
// ------------------------------------------------------------------
interface beam_trigger_scaler_if;
  import beam_trigger_scaler_pkg::*;

  logic [5:0] beam_idx;
  scal_word_t scal_dat;
  logic       count_done;

  modport master (output beam_idx, input scal_dat, input count_done);
  modport slave  (input beam_idx, output scal_dat, output count_done);

endinterface
`default_nettype wire

// File: rtl/beam_trigger_scaler_holdoff_counter.sv
`default_nettype none
// ------------------------------------------------------------------
// beam_holdoff_counter : per-beam holdoff down-counter and saturating live count
// Revision: 1.0
// ------------------------------------------------------------------
module beam_holdoff_counter
  import beam_trigger_scaler_pkg::*;
#(
  parameter int HOLDOFF_CLOCKS = 16,
  parameter int SCAL_BITS      = SCAL_BITS_DEFAULT
) (
  input  wire                  clk,
  input  wire                  rst,
  input  wire                  clear,
  input  wire                  latch,
  input  wire                  trigger,
  output logic [SCAL_BITS-1:0] count
);

  localparam int                  HW             = $clog2(HOLDOFF_CLOCKS + 1);
  localparam logic [HW-1:0]        C_HOLDOFF_LOAD = HW'(HOLDOFF_CLOCKS);
  localparam logic [SCAL_BITS-1:0] C_COUNT_MAX    = '1;

  logic [HW-1:0]        r_holdoff;
  logic [SCAL_BITS-1:0] r_count;
  logic [SCAL_BITS-1:0] w_count;
  logic                 w_hit;

  // count is the live value including this cycle's hit, so the latch sees it.
  always_comb begin
    w_hit   = trigger && (r_holdoff == '0);
    w_count = r_count;
    if (w_hit) begin
      w_count = SCAL_BITS'(sat_inc(24'(r_count), 24'(C_COUNT_MAX)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_holdoff <= '0;
      r_count   <= '0;
    end else begin
      if (r_holdoff != '0) begin
        r_holdoff <= r_holdoff - HW'(1);
      end else if (trigger) begin
        r_holdoff <= C_HOLDOFF_LOAD;
      end
      r_count <= latch ? '0 : w_count;
    end
  end

  assign count = w_count;

endmodule
`default_nettype wire

// File: rtl/beam_trigger_scaler.sv
`default_nettype none
// ------------------------------------------------------------------
// beam_trigger_scaler : gated per-beam trigger rate scaler with latched readout
// Revision: 1.0
// ------------------------------------------------------------------
module beam_trigger_scaler
  import beam_trigger_scaler_pkg::*;
#(
  parameter int          NBEAMS         = 2,
  parameter logic [47:0] TRIGGER_CLOCKS = 48'd375000000,
  parameter int          HOLDOFF_CLOCKS = 16,
  parameter int          SCAL_BITS      = SCAL_BITS_DEFAULT
) (
  input  wire                 ifclk,
  input  wire                 ifclk_rst_i,
  input  wire                 enable_i,
  input  wire  [NBEAMS-1:0]   trigger_i,
  beam_trigger_scaler_if.slave rd
);

  localparam logic [47:0] C_GATE_LAST = TRIGGER_CLOCKS - 48'd1;
  localparam int          IW          = (NBEAMS > 1) ? $clog2(NBEAMS) : 1;

  logic                 r_run;
  logic [47:0]          r_gate_cnt;
  logic                 w_terminal;
  logic [7:0]           r_seq;
  logic [7:0]           w_seq_next;
  logic                 r_done;
  scal_word_t           r_scal;
  scal_word_t           w_scal;
  logic [SCAL_BITS-1:0] w_live       [NBEAMS];
  logic [SCAL_BITS-1:0] r_latch      [NBEAMS];
  logic [SCAL_BITS-1:0] w_latch_next [NBEAMS];

  // r_run delays the first gate cycle by one clock after enable is seen high.
  assign w_terminal = r_run && enable_i && (r_gate_cnt == C_GATE_LAST);
  assign w_seq_next = w_terminal ? r_seq + 8'd1 : r_seq;

  generate
    for (genvar b = 0; b < NBEAMS; b++) begin : g_beam
      beam_holdoff_counter #(
        .HOLDOFF_CLOCKS (HOLDOFF_CLOCKS),
        .SCAL_BITS      (SCAL_BITS)
      ) u_counter (
        .clk     (ifclk),
        .rst     (ifclk_rst_i),
        .clear   (!enable_i),
        .latch   (w_terminal),
        .trigger (trigger_i[b] && r_run),
        .count   (w_live[b])
      );
    end
  endgenerate

  always_comb begin
    w_latch_next = r_latch;
    if (w_terminal) begin
      for (int b = 0; b < NBEAMS; b++) begin
        w_latch_next[b] = w_live[b];
      end
    end
  end

  // Readout looks at next-state data so a read in the done cycle is already new.
  always_comb begin
    w_scal.seq   = w_seq_next;
    w_scal.count = '0;
    if (int'(rd.beam_idx) < NBEAMS) begin
      w_scal.count = COUNT_FIELD_BITS'(w_latch_next[rd.beam_idx[IW-1:0]]);
    end
  end

  always_ff @(posedge ifclk) begin
    if (ifclk_rst_i) begin
      r_run      <= 1'b0;
      r_gate_cnt <= '0;
      r_seq      <= '0;
      r_done     <= 1'b0;
      r_scal     <= '0;
      for (int b = 0; b < NBEAMS; b++) begin
        r_latch[b] <= '0;
      end
    end else begin
      r_done  <= w_terminal;
      r_seq   <= w_seq_next;
      r_scal  <= w_scal;
      r_latch <= w_latch_next;
      if (!enable_i) begin
        r_run      <= 1'b0;
        r_gate_cnt <= '0;
      end else if (!r_run) begin
        r_run <= 1'b1;
      end else if (w_terminal) begin
        r_gate_cnt <= '0;
      end else begin
        r_gate_cnt <= r_gate_cnt + 48'd1;
      end
    end
  end

  assign rd.scal_dat   = r_scal;
  assign rd.count_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_beam_trigger_scaler.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_beam_trigger_scaler : scoreboard bench for beam_trigger_scaler
// Revision: 1.0
// ------------------------------------------------------------------
module tb_beam_trigger_scaler;
  import beam_trigger_scaler_pkg::*;

  typedef struct {
    int seq;
    int c0;
    int c1;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [1:0] trig;
  logic [1:0] trig_b;

  beam_trigger_scaler_if rd_a ();
  beam_trigger_scaler_if rd_b ();

  always #5 clk = ~clk;

  assign trig_b         = 2'b01;
  assign rd_b.beam_idx  = 6'd0;

  beam_trigger_scaler #(
    .NBEAMS(2), .TRIGGER_CLOCKS(48'd100), .HOLDOFF_CLOCKS(4), .SCAL_BITS(24)
  ) dut_a (
    .ifclk(clk), .ifclk_rst_i(rst), .enable_i(enable), .trigger_i(trig), .rd(rd_a)
  );

  // Short-count instance: constant trigger must saturate at 15, not wrap.
  beam_trigger_scaler #(
    .NBEAMS(2), .TRIGGER_CLOCKS(48'd100), .HOLDOFF_CLOCKS(1), .SCAL_BITS(4)
  ) dut_b (
    .ifclk(clk), .ifclk_rst_i(rst), .enable_i(enable), .trigger_i(trig_b), .rd(rd_b)
  );

  exp_t       sb[$];
  int         n_checks   = 0;
  int         n_errors   = 0;
  int         probe_cnt  = 0;
  int         probe_seen = 0;
  bit         exp_done   = 1'b0;
  logic [1:0] gpat [100];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // One clock: check done against expectation, then drive this cycle's inputs.
  task automatic tick(input logic [1:0] t, input logic en, input logic r);
    @(negedge clk);
    check_eq("done_a", 32'(rd_a.count_done), 32'(exp_done));
    check_eq("done_b", 32'(rd_b.count_done), 32'(exp_done));
    if (exp_done) check_eq("b_sat_count", 32'(rd_b.scal_dat.count), 32'd15);
    exp_done = 1'b0;
    trig     = t;
    enable   = en;
    rst      = r;
    @(posedge clk);
  endtask

  task automatic run_gate(input int abort_at);
    for (int k = 0; k < 100; k++) begin
      if (k == abort_at) begin
        tick(2'b00, 1'b1, 1'b1);
        return;
      end
      tick(gpat[k], 1'b1, 1'b0);
    end
    exp_done = 1'b1;
  endtask

  task automatic clr_pat();
    for (int k = 0; k < 100; k++) gpat[k] = 2'b00;
  endtask

  task automatic push(input int s, input int a, input int b);
    exp_t e;
    e.seq = s;
    e.c0  = a;
    e.c1  = b;
    sb.push_back(e);
  endtask

  // Monitor: on each done pulse (or probe request) read beams 0, 1 and an unused index.
  initial begin : monitor
    exp_t        e;
    logic [31:0] w;
    rd_a.beam_idx = 6'd0;
    forever begin
      @(negedge clk);
      if (rd_a.count_done || probe_cnt != probe_seen) begin
        if (!rd_a.count_done) probe_seen++;
        check_eq("sb_pending", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          w = {e.seq[7:0], e.c0[23:0]};
          check_eq("read_idx0", rd_a.scal_dat, w);
          rd_a.beam_idx = 6'd1;
          @(negedge clk);
          w = {e.seq[7:0], e.c1[23:0]};
          check_eq("read_idx1", rd_a.scal_dat, w);
          rd_a.beam_idx = 6'd5;
          @(negedge clk);
          w = {e.seq[7:0], 24'h0};
          check_eq("read_idx5", rd_a.scal_dat, w);
          rd_a.beam_idx = 6'd0;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1);
  end

  initial begin : stim
    rst    = 1'b1;
    enable = 1'b0;
    trig   = 2'b00;
    repeat (3) tick(2'b00, 1'b0, 1'b1);
    tick(2'b00, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("rst_scal_a", rd_a.scal_dat, 32'h0);
    check_eq("rst_done_a", 32'(rd_a.count_done), 32'd0);

    tick(2'b00, 1'b1, 1'b0);

    // Gate 1: three isolated beam0 pulses.
    clr_pat(); gpat[10] = 2'b01; gpat[30] = 2'b01; gpat[50] = 2'b01;
    push(1, 3, 0); run_gate(-1);

    // Gates 2, 3: beam1 held high, one count per five cycles.
    for (int g = 2; g <= 3; g++) begin
      clr_pat();
      for (int k = 0; k < 100; k++) gpat[k] = 2'b10;
      push(g, 0, 20); run_gate(-1);
    end

    // Gate 4: trigger on the terminal cycle; gate 5 quiet; gate 6 trigger at cycle 0.
    clr_pat(); gpat[99] = 2'b01; push(4, 1, 0); run_gate(-1);
    clr_pat(); push(5, 0, 0); run_gate(-1);
    clr_pat(); gpat[0] = 2'b01; gpat[99] = 2'b10; push(6, 1, 1); run_gate(-1);

    // Gate 7: beam1 holdoff from cycle 99 swallows the cycle-2 pulse.
    clr_pat(); gpat[2] = 2'b10; gpat[20] = 2'b10; push(7, 0, 1); run_gate(-1);

    // Enable low: no done, latched data and seq hold.
    for (int i = 0; i < 200; i++) begin
      tick(2'b00, 1'b0, 1'b0);
      if (i == 20) begin
        push(7, 0, 1);
        probe_cnt++;
      end
    end

    tick(2'b00, 1'b1, 1'b0);
    clr_pat();
    for (int k = 0; k < 10; k++) gpat[k] = 2'b01;
    push(8, 2, 0); run_gate(-1);

    // Reset at gate cycle 60 discards the partial gate.
    clr_pat(); gpat[10] = 2'b01; run_gate(60);
    push(0, 0, 0);
    probe_cnt++;
    tick(2'b00, 1'b1, 1'b0);
    clr_pat(); gpat[40] = 2'b10; push(1, 0, 1); run_gate(-1);

    repeat (6) tick(2'b00, 1'b1, 1'b0);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    check_eq("probes_served", 32'(probe_seen), 32'(probe_cnt));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
